enc_scan_iter: RTL

//   Parametrised set-bit iterator, successor to the fixed 64-bit priority encoder.

---
 rtl/enc_scan_iter_pkg.sv | 15 +
 rtl/enc_scan_iter_if.sv | 31 +++
 rtl/enc_scan_iter_prio.sv | 47 ++++
 rtl/enc_scan_iter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/enc_scan_iter_pkg.sv
// Shared types and helpers for the set-bit iterator: FSM encoding and index-width helper.
package enc_pkg;

  typedef enum logic [0:0] {
    ENC_IDLE,
    ENC_SCAN
  } enc_state_t;

  localparam int ENC_MAX_W = 256;

  function automatic int enc_idx_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/enc_scan_iter_if.sv
// Mask-in / index-out stream bundle for enc_scan_iter.
// Both sides are valid/ready: a transfer happens on a rising clock edge where valid and
// ready are both high; once valid is raised, the payload stays stable until that edge.
interface enc_scan_iter_if #(
  parameter int DATA_W = 64
);
  import enc_pkg::*;

  localparam int IDX_W = enc_idx_w(DATA_W);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [IDX_W-1:0]  out_index_o;
  logic [IDX_W:0]    out_seq_o;
  logic              out_last_o;
  logic              out_empty_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_index_o, out_seq_o, out_last_o, out_empty_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_index_o, out_seq_o, out_last_o, out_empty_o
  );

endinterface

// File: rtl/enc_scan_iter_prio.sv
// Combinational two-level priority encoder: per-group OR and in-group index, then group select.
module enc_prio import enc_pkg::*; #(
  parameter int DATA_W    = 64,
  parameter int GRP_W     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic [DATA_W-1:0]            mask_i,
  output logic [enc_idx_w(DATA_W)-1:0] idx_o,
  output logic                         any_o
);

  localparam int IDX_W = enc_idx_w(DATA_W);
  localparam int NGRP  = DATA_W / GRP_W;

  logic             grp_any [NGRP];
  logic [IDX_W-1:0] grp_sub [NGRP];

  // Later matches overwrite earlier ones, so the scan order picks the winning end.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_any[g] = 1'b0;
      grp_sub[g] = '0;
      for (int b = 0; b < GRP_W; b++) begin
        int bb;
        bb = LSB_FIRST ? (GRP_W - 1 - b) : b;
        if (mask_i[g*GRP_W + bb]) begin
          grp_any[g] = 1'b1;
          grp_sub[g] = IDX_W'(bb);
        end
      end
    end
  end

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int gg = 0; gg < NGRP; gg++) begin
      int g;
      g = LSB_FIRST ? (NGRP - 1 - gg) : gg;
      if (grp_any[g]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(g * GRP_W) | grp_sub[g];
      end
    end
  end

endmodule

// File: rtl/enc_scan_iter.sv
// Set-bit iterator: accepts a mask, then emits one set-bit index per beat with seq/last/empty.
module enc_scan_iter import enc_pkg::*; #(
  parameter int DATA_W    = 64,
  parameter int GRP_W     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  enc_scan_iter_if.slave  bus,
  output enc_state_t      dbg_state_o
);

  localparam int IDX_W = enc_idx_w(DATA_W);
  localparam logic [IDX_W:0] CNT_ONE = 1;

  enc_state_t        state_q, state_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic [IDX_W:0]    out_seq_q, out_seq_d;
  logic              out_last_q, out_last_d;
  logic              out_empty_q, out_empty_d;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic              slot_free, accept, load, last_taken;

  enc_prio #(
    .DATA_W    (DATA_W),
    .GRP_W     (GRP_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio (
    .mask_i (mask_q),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  always_comb begin
    slot_free  = !out_valid_q || bus.out_ready_i;
    accept     = (state_q == ENC_IDLE) && bus.in_valid_i && !flush_i;
    // cnt_q == 0 with an empty mask is the zero-mask case that still owes one dummy beat.
    load       = (state_q == ENC_SCAN) && slot_free && ((mask_q != '0) || (cnt_q == '0));
    last_taken = out_valid_q && bus.out_ready_i && out_last_q;

    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_seq_d   = out_seq_q;
    out_last_d  = out_last_q;
    out_empty_d = out_empty_q;

    if (flush_i) begin
      state_d     = ENC_IDLE;
      mask_d      = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_empty_d = 1'b0;
    end else begin
      case (state_q)
        ENC_IDLE: begin
          if (accept) begin
            state_d = ENC_SCAN;
            mask_d  = bus.in_data_i;
            cnt_d   = '0;
          end
        end
        ENC_SCAN: begin
          if (last_taken) begin
            state_d     = ENC_IDLE;
            out_valid_d = 1'b0;
          end else if (load) begin
            if (enc_any) mask_d[enc_idx] = 1'b0;
            out_valid_d = 1'b1;
            out_index_d = enc_idx;
            out_seq_d   = cnt_q;
            cnt_d       = cnt_q + CNT_ONE;
            out_last_d  = (mask_d == '0);
            out_empty_d = !enc_any;
          end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ENC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ENC_IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_seq_q   <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_seq_q   <= out_seq_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
    end
  end

  assign bus.in_ready_o  = (state_q == ENC_IDLE);
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_index_o = out_index_q;
  assign bus.out_seq_o   = out_seq_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.out_empty_o = out_empty_q;
  assign dbg_state_o     = state_q;

endmodule
